spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Sequences chip select, start pulse, completion wait (with watchdog) and hold time.
module spi_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          err,
  output logic                          spi_start,
  output logic [DATA_WIDTH-1:0]         spi_data,
  input  logic                          spi_done,
  output logic [NUM_REQ-1:0]            cs_n,
  output logic                          busy
);

  localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAX_CNT = (MAX_SH > TIMEOUT) ? MAX_SH : TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = $clog2(NUM_REQ);

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD} state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;
  logic [IW-1:0]           lastGrant_q;
  logic                    abort_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic [NUM_REQ-1:0]      ack_q;
  logic                    err_q;
  logic                    spiStart_q;
  logic [DATA_WIDTH-1:0]   spiData_q;
  logic [NUM_REQ-1:0]      csN_q;
  logic                    busy_q;

  logic                    winValid_d;
  logic [IW-1:0]           winIdx_d;
  logic [NUM_REQ-1:0]      winOneHot_d;
  logic [DATA_WIDTH-1:0]   winData_d;
  int                      cand;

  // Search starts just past the previous winner so every requester gets a turn.
  always_comb begin
    winValid_d = 1'b0;
    winIdx_d   = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(lastGrant_q) + k) % NUM_REQ;
      if (!winValid_d && req[IW'(cand)]) begin
        winValid_d = 1'b1;
        winIdx_d   = IW'(cand);
      end
    end
  end

  always_comb begin
    winData_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == winIdx_d) winData_d = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign winOneHot_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << winIdx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      lastGrant_q <= IW'(NUM_REQ - 1);
      abort_q     <= 1'b0;
      grant_q     <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      spiStart_q  <= 1'b0;
      spiData_q   <= '0;
      csN_q       <= '1;
      busy_q      <= 1'b0;
    end else begin
      ack_q      <= '0;
      err_q      <= 1'b0;
      spiStart_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (winValid_d) begin
            state_q   <= SETUP;
            idx_q     <= winIdx_d;
            grant_q   <= winOneHot_d;
            csN_q     <= ~winOneHot_d;
            spiData_q <= winData_d;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_q    <= START;
            spiStart_q <= 1'b1;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        START: begin
          state_q <= WAIT;
          cnt_q   <= '0;
          abort_q <= 1'b0;
        end
        // A done arriving in the last watchdog cycle still counts as success.
        WAIT: begin
          if (spi_done) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            abort_q <= 1'b0;
          end else if (cnt_q == WAIT_LAST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            abort_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q     <= IDLE;
            csN_q       <= '1;
            grant_q     <= '0;
            ack_q       <= grant_q;
            err_q       <= abort_q;
            lastGrant_q <= idx_q;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign spi_start = spiStart_q;
  assign spi_data  = spiData_q;
  assign cs_n      = csN_q;
  assign busy      = busy_q;

endmodule
